// File: rtl/pin_debounce_if.sv
// Signal bundle for the pin debouncer: raw pin in, clean level, edge strobes
// and the press counter out. The debouncer itself takes the slave side.
interface pin_debounce_if #(
    parameter int NW = 8
);
    logic          I;
    logic          O;
    logic          RISE;
    logic          FALL;
    logic [NW-1:0] N;

    modport master (output I, input O, input RISE, input FALL, input N);
    modport slave  (input I, output O, output RISE, output FALL, output N);
endinterface

// File: rtl/pin_debounce.sv
// Debounces one asynchronous board pin: two-flop synchroniser, a
// consecutive-disagreement counter, registered rise/fall strobes and a
// wrapping count of debounced presses.
module pin_debounce #(
    parameter int THRESH = 120000,
    parameter int CW     = 17,
    parameter int NW     = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    pin_debounce_if.slave bus
);
    localparam logic [CW-1:0] LP_LAST = CW'(THRESH - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic [CW-1:0] r_c;
    logic          r_o;
    logic          r_rise;
    logic          r_fall;
    logic [NW-1:0] r_n;

    logic          w_s;
    logic          w_last;

    assign w_s    = r_sync1;
    assign w_last = (r_c == LP_LAST);

    // Synchronise the pin, count consecutive samples disagreeing with O and
    // commit the new level once the run reaches THRESH samples.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_c     <= '0;
            r_o     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_n     <= '0;
        end else begin
            r_sync0 <= bus.I;
            r_sync1 <= r_sync0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (w_s == r_o) begin
                r_c <= '0;
            end else if (w_last) begin
                r_o    <= w_s;
                r_c    <= '0;
                r_rise <= w_s;
                r_fall <= ~w_s;
                if (w_s) begin
                    r_n <= r_n + NW'(1);
                end
            end else begin
                r_c <= r_c + CW'(1);
            end
        end
    end

    assign bus.O    = r_o;
    assign bus.RISE = r_rise;
    assign bus.FALL = r_fall;
    assign bus.N    = r_n;
endmodule

// File: tb/tb_pin_debounce.sv
// Self-checking bench for pin_debounce: a THRESH=4 instance checked against
// a sliding-window reference model plus vector tables and hand sequences,
// and a THRESH=1 instance for the minimum-latency corner.
module tb_pin_debounce;
    logic CLK;
    logic RESET;
    int   n_tests = 0;
    int   n_fail  = 0;

    pin_debounce_if #(.NW(8)) bus4 ();
    pin_debounce_if #(.NW(8)) bus1 ();

    pin_debounce #(.THRESH(4), .CW(3), .NW(8)) dut4 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus4.slave)
    );

    pin_debounce #(.THRESH(1), .CW(1), .NW(8)) dut1 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus1.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: the filter sees the pin two edges late; O flips when
    // the last THRESH filter samples all differ from O.
    localparam int T = 4;
    logic       m_o, m_rise, m_fall, m_s;
    logic [7:0] m_n;
    logic       dly[$];
    logic       win[$];
    int         m_diff;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_o = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_n = 8'd0;
            dly = '{1'b0, 1'b0};
            win.delete();
        end else begin
            dly.push_back(bus4.I);
            m_s = dly.pop_front();
            m_rise = 1'b0;
            m_fall = 1'b0;
            win.push_back(m_s);
            if (win.size() > T) void'(win.pop_front());
            m_diff = 0;
            foreach (win[k]) if (win[k] != m_o) m_diff++;
            if (m_diff == T) begin
                m_o = m_s;
                m_rise = m_s;
                m_fall = !m_s;
                if (m_s) m_n = m_n + 8'd1;
                win.delete();
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive the pin, take one edge, then compare the THRESH=4 DUT with the model.
    task automatic step(input logic i);
        bus4.I = i;
        @(posedge CLK);
        #2;
        chk("model", {bus4.O, bus4.RISE, bus4.FALL, bus4.N}, {m_o, m_rise, m_fall, m_n});
    endtask

    typedef struct packed {
        logic       i;
        logic       o;
        logic       r;
        logic       f;
        logic [7:0] n;
    } vec_t;

    vec_t       tbl[16];
    logic [10:0] t1_exp[5];
    int nr, nf;
    logic lvl;
    int   len;

    initial begin
        // clean press then clean release, one entry per edge from idle
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        // THRESH=1: {O, RISE, FALL, N} after each edge of a one-cycle pulse
        t1_exp[0] = {1'b0, 1'b0, 1'b0, 8'd0};
        t1_exp[1] = {1'b0, 1'b0, 1'b0, 8'd0};
        t1_exp[2] = {1'b1, 1'b1, 1'b0, 8'd1};
        t1_exp[3] = {1'b0, 1'b0, 1'b1, 8'd1};
        t1_exp[4] = {1'b0, 1'b0, 1'b0, 8'd1};

        RESET = 1'b1;
        bus4.I = 1'b0;
        bus1.I = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        chk("rst_init4", {bus4.O, bus4.RISE, bus4.FALL, bus4.N}, 0);
        chk("rst_init1", {bus1.O, bus1.RISE, bus1.FALL, bus1.N}, 0);
        RESET = 1'b0;

        // get O and N non-zero, then reset asynchronously mid-cycle with I=1
        repeat (8) step(1'b1);
        chk("pre_rst_o", bus4.O, 1);
        chk("pre_rst_n", bus4.N, 1);
        RESET = 1'b1;
        #1;
        chk("async_rst", {bus4.O, bus4.RISE, bus4.FALL, bus4.N}, 0);
        repeat (3) step(1'b1);
        chk("rst_held", {bus4.O, bus4.RISE, bus4.FALL, bus4.N}, 0);
        RESET = 1'b0;

        for (int j = 0; j < 20; j++) begin
            step(1'b0);
            chk("idle", {bus4.O, bus4.RISE, bus4.FALL, bus4.N}, 0);
        end

        for (int j = 0; j < 16; j++) begin
            step(tbl[j].i);
            chk($sformatf("vec%0d", j), {bus4.O, bus4.RISE, bus4.FALL, bus4.N},
                {tbl[j].o, tbl[j].r, tbl[j].f, tbl[j].n});
        end

        // bounce 1,1,1,0 never reaches four agreeing samples
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                step(j != 3);
                chk("bounce_o", {bus4.O, bus4.RISE}, 0);
            end
        end
        chk("bounce_n", bus4.N, 1);
        for (int j = 1; j <= 8; j++) begin
            step(1'b1);
            chk("bounce_hold_o", bus4.O, (j >= 6));
            chk("bounce_hold_rise", bus4.RISE, (j == 6));
        end
        chk("bounce_hold_n", bus4.N, 2);
        repeat (8) step(1'b0);

        // wrap the press counter with clean toggles
        RESET = 1'b1;
        repeat (2) step(1'b0);
        RESET = 1'b0;
        nr = 0;
        nf = 0;
        for (int p = 0; p < 255; p++) begin
            for (int j = 1; j <= 8; j++) begin
                step(1'b1);
                if (bus4.RISE) nr++;
            end
            for (int j = 1; j <= 8; j++) begin
                step(1'b0);
                if (bus4.FALL) nf++;
                chk("fall_timing", bus4.FALL, (j == 6));
            end
        end
        chk("n_255", bus4.N, 255);
        chk("rise_count", nr, 255);
        chk("fall_count", nf, 255);
        repeat (8) step(1'b1);
        chk("n_wrap", bus4.N, 0);
        chk("o_after_wrap", bus4.O, 1);
        repeat (8) step(1'b0);

        // reset while the counter is part-way through a rise
        repeat (4) step(1'b1);
        RESET = 1'b1;
        #1;
        chk("midcount_rst_o", bus4.O, 0);
        repeat (2) step(1'b1);
        RESET = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            step(1'b1);
            chk("midcount_o", bus4.O, (j >= 6));
            chk("midcount_n", bus4.N, (j >= 6) ? 1 : 0);
        end

        // THRESH=1 single-cycle pulse
        for (int j = 0; j < 5; j++) begin
            bus1.I = (j == 0);
            step(bus4.I);
            chk($sformatf("t1_step%0d", j), {bus1.O, bus1.RISE, bus1.FALL, bus1.N}, t1_exp[j]);
        end

        // random runs of random length against the model
        for (int r = 0; r < 150; r++) begin
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            repeat (len) step(lvl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
